// File: rtl/nettlp_tx_encap.sv
// Wraps one outbound TLP in an Eth/IPv4/UDP/NetTLP frame (48-byte header + TLP bytes).
// Optional build macro NETTLP_TSTAMP_EN: carry a free-running 32-bit timestamp in the NetTLP header.
module nettlp_tx_encap #(
  parameter int          DATA_WIDTH   = 64,
  parameter int          SEQ_WIDTH    = 10,
  parameter logic [15:0] UDP_PORT_CPL = 16'h3000,
  parameter logic [15:0] UDP_PORT_MR  = 16'h4000,
  parameter logic [7:0]  IP_TTL       = 8'd64
) (
  input  logic                      eth_clk,
  input  logic                      eth_rst,
  input  logic [47:0]               cfg_src_mac,
  input  logic [47:0]               cfg_dst_mac,
  input  logic [31:0]               cfg_src_ip,
  input  logic [31:0]               cfg_dst_ip,
  input  logic                      s_tvalid,
  output logic                      s_tready,
  input  logic [DATA_WIDTH-1:0]     s_tdata,
  input  logic [DATA_WIDTH/8-1:0]   s_tkeep,
  input  logic                      s_tlast,
  input  logic [11:0]               s_tlp_len,
  input  logic                      s_tlp_is_cpl,
  output logic                      m_tvalid,
  input  logic                      m_tready,
  output logic [DATA_WIDTH-1:0]     m_tdata,
  output logic [DATA_WIDTH/8-1:0]   m_tkeep,
  output logic                      m_tlast,
  output logic [SEQ_WIDTH-1:0]      seq_num
);

  localparam int HDR_BITS  = 384;
  localparam int HDR_BEATS = HDR_BITS / DATA_WIDTH;

  typedef enum logic [1:0] {IDLE, HDR_PREP, HDR, PAYLOAD} state_t;

  state_t               state;
  logic [2:0]           beat_cnt;
  logic [11:0]          cap_len;
  logic                 cap_cpl;
  logic [SEQ_WIDTH-1:0] cap_seq;
  logic [SEQ_WIDTH-1:0] seq_cnt;
  logic [47:0]          cap_src_mac;
  logic [47:0]          cap_dst_mac;
  logic [31:0]          cap_src_ip;
  logic [31:0]          cap_dst_ip;
  logic [15:0]          ip_csum;
  logic [31:0]          ts_field;

`ifdef NETTLP_TSTAMP_EN
  logic [31:0] ts_cnt;
  logic [31:0] cap_ts;

  always_ff @(posedge eth_clk) begin
    if (eth_rst) begin
      ts_cnt <= '0;
      cap_ts <= '0;
    end else begin
      ts_cnt <= ts_cnt + 32'd1;
      if (state == IDLE && s_tvalid)
        cap_ts <= ts_cnt;
    end
  end

  assign ts_field = cap_ts;
`else
  assign ts_field = '0;
`endif

  logic [15:0] tot_len;
  logic [15:0] udp_len;
  logic [15:0] udp_port;
  logic [19:0] csum_sum;
  logic [16:0] csum_f1;
  logic [15:0] csum_f2;
  logic [15:0] csum_calc;

  assign tot_len  = 16'd34 + {4'b0, cap_len};
  assign udp_len  = 16'd14 + {4'b0, cap_len};
  assign udp_port = cap_cpl ? UDP_PORT_CPL : UDP_PORT_MR;

  // Two folds suffice: a 20-bit sum of ten words folds to at most 17 bits, then 16.
  always_comb begin
    csum_sum  = 20'h04500 + {4'b0, tot_len} + 20'h04000 + {4'b0, IP_TTL, 8'd17}
              + {4'b0, cap_src_ip[31:16]} + {4'b0, cap_src_ip[15:0]}
              + {4'b0, cap_dst_ip[31:16]} + {4'b0, cap_dst_ip[15:0]};
    csum_f1   = {1'b0, csum_sum[15:0]} + {13'b0, csum_sum[19:16]};
    csum_f2   = csum_f1[15:0] + {15'b0, csum_f1[16]};
    csum_calc = ~csum_f2;
  end

  logic [HDR_BITS-1:0] hdr_be;
  logic [HDR_BITS-1:0] hdr_le;

  // hdr_be is in wire order (MSB first); hdr_le puts wire byte k at [8k+7:8k].
  always_comb begin
    hdr_be = {cap_dst_mac, cap_src_mac, 16'h0800,
              8'h45, 8'h00, tot_len, 16'h0000, 16'h4000, IP_TTL, 8'd17, ip_csum,
              cap_src_ip, cap_dst_ip,
              udp_port, udp_port, udp_len, 16'h0000,
              16'(cap_seq), ts_field};
    hdr_le = '0;
    for (int unsigned k = 0; k < HDR_BITS / 8; k++)
      hdr_le[8*k +: 8] = hdr_be[HDR_BITS-1-8*k -: 8];
  end

  always_comb begin
    s_tready = 1'b0;
    m_tvalid = 1'b0;
    m_tdata  = '0;
    m_tkeep  = '0;
    m_tlast  = 1'b0;
    case (state)
      HDR: begin
        m_tvalid = 1'b1;
        m_tdata  = hdr_le[int'(beat_cnt)*DATA_WIDTH +: DATA_WIDTH];
        m_tkeep  = '1;
      end
      PAYLOAD: begin
        s_tready = m_tready;
        m_tvalid = s_tvalid;
        m_tdata  = s_tdata;
        m_tkeep  = s_tkeep;
        m_tlast  = s_tlast;
      end
      default: ;
    endcase
  end

  assign seq_num = seq_cnt;

  always_ff @(posedge eth_clk) begin
    if (eth_rst) begin
      state       <= IDLE;
      beat_cnt    <= '0;
      cap_len     <= '0;
      cap_cpl     <= 1'b0;
      cap_seq     <= '0;
      seq_cnt     <= '0;
      cap_src_mac <= '0;
      cap_dst_mac <= '0;
      cap_src_ip  <= '0;
      cap_dst_ip  <= '0;
      ip_csum     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (s_tvalid) begin
            cap_len     <= s_tlp_len;
            cap_cpl     <= s_tlp_is_cpl;
            cap_seq     <= seq_cnt;
            cap_src_mac <= cfg_src_mac;
            cap_dst_mac <= cfg_dst_mac;
            cap_src_ip  <= cfg_src_ip;
            cap_dst_ip  <= cfg_dst_ip;
            beat_cnt    <= '0;
            state       <= HDR_PREP;
          end
        end
        HDR_PREP: begin
          ip_csum <= csum_calc;
          state   <= HDR;
        end
        HDR: begin
          if (m_tready) begin
            if (beat_cnt == 3'(HDR_BEATS - 1)) begin
              beat_cnt <= '0;
              state    <= PAYLOAD;
            end else begin
              beat_cnt <= beat_cnt + 3'd1;
            end
          end
        end
        PAYLOAD: begin
          if (s_tvalid && m_tready && s_tlast) begin
            seq_cnt <= seq_cnt + 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nettlp_tx_encap.sv
// Scoreboard bench for nettlp_tx_encap: a byte-level frame model feeds expected beats to a monitor.
module tb_nettlp_tx_encap;

  localparam int DW  = 64;
  localparam int BY  = DW / 8;
  localparam int HB  = 48 / BY;
  localparam int SQW = 10;

  logic           eth_clk = 1'b0;
  logic           eth_rst;
  logic [47:0]    cfg_src_mac, cfg_dst_mac;
  logic [31:0]    cfg_src_ip, cfg_dst_ip;
  logic           s_tvalid, s_tready, s_tlast, s_tlp_is_cpl;
  logic [DW-1:0]  s_tdata;
  logic [BY-1:0]  s_tkeep;
  logic [11:0]    s_tlp_len;
  logic           m_tvalid, m_tready, m_tlast;
  logic [DW-1:0]  m_tdata;
  logic [BY-1:0]  m_tkeep;
  logic [SQW-1:0] seq_num;

  nettlp_tx_encap #(.DATA_WIDTH(DW), .SEQ_WIDTH(SQW), .UDP_PORT_CPL(16'h3000),
                    .UDP_PORT_MR(16'h4000), .IP_TTL(8'd64)) dut (
    .eth_clk(eth_clk), .eth_rst(eth_rst),
    .cfg_src_mac(cfg_src_mac), .cfg_dst_mac(cfg_dst_mac),
    .cfg_src_ip(cfg_src_ip), .cfg_dst_ip(cfg_dst_ip),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata), .s_tkeep(s_tkeep),
    .s_tlast(s_tlast), .s_tlp_len(s_tlp_len), .s_tlp_is_cpl(s_tlp_is_cpl),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tkeep(m_tkeep),
    .m_tlast(m_tlast), .seq_num(seq_num)
  );

  always #5 eth_clk = ~eth_clk;

  typedef struct {
    logic [DW-1:0] data;
    logic [BY-1:0] mask;
    logic [BY-1:0] keep;
    logic          last;
  } beat_t;

  beat_t exp_q[$];
  int    n_cmp  = 0;
  int    n_bad  = 0;
  int    tb_seq = 0;
  int    rdy_mode = 0;
  bit    mon_en = 1'b0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  task automatic finish_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  endtask

  always @(posedge eth_clk) begin
    #1;
    case (rdy_mode)
      0:       m_tready = 1'b1;
      1:       m_tready = ~m_tready;
      default: m_tready = ($urandom_range(0, 3) != 0);
    endcase
  end

  always @(negedge eth_clk) begin : monitor
    static bit            stall_pend = 1'b0;
    static logic [DW-1:0] stall_data = '0;
    beat_t                e;
    logic [DW-1:0]        mbits;
    if (!mon_en || eth_rst) begin
      stall_pend = 1'b0;
    end else begin
      if (stall_pend) begin
        chk("hold_valid", 128'(m_tvalid), 128'(1));
        chk("hold_data", 128'(m_tdata), 128'(stall_data));
      end
      stall_pend = m_tvalid && !m_tready;
      stall_data = m_tdata;
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL extra_beat: got %h expected no beat", m_tdata);
        end else begin
          e = exp_q.pop_front();
          for (int k = 0; k < BY; k++) mbits[8*k +: 8] = {8{e.mask[k]}};
          chk("beat_data", 128'(m_tdata & mbits), 128'(e.data & mbits));
          chk("beat_keep", 128'(m_tkeep), 128'(e.keep));
          chk("beat_last", 128'(m_tlast), 128'(e.last));
        end
      end
    end
  end

  // Waits for the current s_ beat to be accepted; returns at posedge+1.
  task automatic wait_hs();
    int n = 0;
    @(negedge eth_clk);
    while (!s_tready) begin
      n++;
      if (n > 2000) begin
        n_cmp++;
        n_bad++;
        $display("FAIL hs_timeout: got no s_tready expected handshake within 2000 cycles");
        finish_run();
      end
      @(negedge eth_clk);
    end
    @(posedge eth_clk);
    #1;
  endtask

  task automatic send_frame(input int len, input bit cpl);
    logic [7:0]  h [48];
    logic [7:0]  pl [];
    beat_t       pb [$];
    beat_t       b;
    logic [47:0] smac, dmac;
    logic [31:0] sip, dip;
    logic [15:0] port, totl, ulen, sq, ck;
    int unsigned sum;
    int          nb;
    smac = {16'($urandom), $urandom};
    dmac = {16'($urandom), $urandom};
    sip  = $urandom;
    dip  = $urandom;
    cfg_src_mac = smac; cfg_dst_mac = dmac; cfg_src_ip = sip; cfg_dst_ip = dip;
    port = cpl ? 16'h3000 : 16'h4000;
    totl = 16'(34 + len);
    ulen = 16'(14 + len);
    sq   = 16'(tb_seq);
    for (int i = 0; i < 6; i++) begin
      h[i]     = dmac[47-8*i -: 8];
      h[6 + i] = smac[47-8*i -: 8];
    end
    h[12] = 8'h08; h[13] = 8'h00; h[14] = 8'h45; h[15] = 8'h00;
    h[16] = totl[15:8]; h[17] = totl[7:0]; h[18] = 8'h00; h[19] = 8'h00;
    h[20] = 8'h40; h[21] = 8'h00; h[22] = 8'd64; h[23] = 8'd17;
    h[24] = 8'h00; h[25] = 8'h00;
    for (int i = 0; i < 4; i++) begin
      h[26 + i] = sip[31-8*i -: 8];
      h[30 + i] = dip[31-8*i -: 8];
    end
    h[34] = port[15:8]; h[35] = port[7:0]; h[36] = port[15:8]; h[37] = port[7:0];
    h[38] = ulen[15:8]; h[39] = ulen[7:0]; h[40] = 8'h00; h[41] = 8'h00;
    h[42] = sq[15:8]; h[43] = sq[7:0];
    for (int i = 44; i < 48; i++) h[i] = 8'h00;
    sum = 0;
    for (int i = 0; i < 10; i++) sum += {16'h0, h[14 + 2*i], h[15 + 2*i]};
    while ((sum >> 16) != 0) sum = (sum & 32'hFFFF) + (sum >> 16);
    ck = ~sum[15:0];
    h[24] = ck[15:8]; h[25] = ck[7:0];
    for (int j = 0; j < HB; j++) begin
      for (int k = 0; k < BY; k++) b.data[8*k +: 8] = h[j*BY + k];
      b.keep = '1;
      b.mask = '1;
`ifdef NETTLP_TSTAMP_EN
      for (int k = 0; k < BY; k++) if (j*BY + k >= 44) b.mask[k] = 1'b0;
`endif
      b.last = 1'b0;
      exp_q.push_back(b);
    end
    pl = new[len];
    foreach (pl[i]) pl[i] = 8'($urandom);
    nb = (len + BY - 1) / BY;
    for (int j = 0; j < nb; j++) begin
      b.data = '0;
      b.keep = '0;
      for (int k = 0; k < BY; k++)
        if (j*BY + k < len) begin
          b.data[8*k +: 8] = pl[j*BY + k];
          b.keep[k] = 1'b1;
        end
      b.mask = b.keep;
      b.last = (j == nb - 1);
      exp_q.push_back(b);
      pb.push_back(b);
    end
    s_tlp_len = 12'(len);
    s_tlp_is_cpl = cpl;
    for (int j = 0; j < nb; j++) begin
      s_tdata = pb[j].data;
      s_tkeep = pb[j].keep;
      s_tlast = pb[j].last;
      s_tvalid = 1'b1;
      if (j == 0) begin
        // Header fields are already captured after this edge; perturb the config.
        @(posedge eth_clk);
        #1;
        cfg_src_mac = {16'($urandom), $urandom};
        cfg_dst_ip = $urandom;
        s_tlp_len = 12'($urandom);
        s_tlp_is_cpl = ~cpl;
      end
      wait_hs();
    end
    s_tvalid = 1'b0;
    s_tlast = 1'b0;
    tb_seq = (tb_seq + 1) % (1 << SQW);
    chk("seq_num", 128'(seq_num), 128'(tb_seq));
  endtask

  initial begin
    eth_rst = 1'b1;
    s_tvalid = 1'b0; s_tdata = '0; s_tkeep = '0; s_tlast = 1'b0;
    s_tlp_len = '0; s_tlp_is_cpl = 1'b0;
    cfg_src_mac = '0; cfg_dst_mac = '0; cfg_src_ip = '0; cfg_dst_ip = '0;
    repeat (3) @(posedge eth_clk);
    #1;
    chk("rst_m_tvalid", 128'(m_tvalid), 128'(0));
    chk("rst_s_tready", 128'(s_tready), 128'(0));
    chk("rst_m_tdata", 128'(m_tdata), 128'(0));
    chk("rst_m_tlast", 128'(m_tlast), 128'(0));
    chk("rst_seq_num", 128'(seq_num), 128'(0));
    eth_rst = 1'b0;
    mon_en = 1'b1;

    rdy_mode = 0;
    send_frame(16, 1'b1);
    send_frame(12, 1'b0);
    send_frame(1, 1'b1);
    for (int f = 3; f < 1025; f++) begin
      rdy_mode = (f / 100) % 3;
      send_frame($urandom_range(1, 32), 1'($urandom));
    end
    chk("seq_wrap", 128'(seq_num), 128'(1));

    rdy_mode = 1;
    for (int f = 0; f < 6; f++) send_frame($urandom_range(1, 40), 1'($urandom));

    // Abandon a frame with a reset pulse during its third header beat.
    rdy_mode = 0;
    mon_en = 1'b0;
    @(posedge eth_clk);
    #1;
    s_tlp_len = 12'd20; s_tlp_is_cpl = 1'b0;
    s_tdata = {$urandom, $urandom}; s_tkeep = '1; s_tlast = 1'b0; s_tvalid = 1'b1;
    repeat (4) @(posedge eth_clk);
    #1;
    chk("pre_rst_valid", 128'(m_tvalid), 128'(1));
    eth_rst = 1'b1;
    s_tvalid = 1'b0;
    @(posedge eth_clk);
    #1;
    eth_rst = 1'b0;
    chk("mid_rst_m_tvalid", 128'(m_tvalid), 128'(0));
    chk("mid_rst_s_tready", 128'(s_tready), 128'(0));
    chk("mid_rst_seq_num", 128'(seq_num), 128'(0));
    exp_q.delete();
    tb_seq = 0;
    mon_en = 1'b1;
    send_frame(24, 1'b1);
    rdy_mode = 2;
    send_frame(8, 1'b0);

    repeat (4) @(posedge eth_clk);
    chk("queue_empty", 128'(exp_q.size()), 128'(0));
    finish_run();
  end

endmodule

// File: doc/nettlp_tx_encap.md
Name: nettlp_tx_encap

Overview:
Wraps one outbound TLP into a complete NetTLP Ethernet frame. The frame is Eth, IPv4, UDP and NetTLP headers (48 bytes), followed by the TLP bytes.
- Generalises the fixed 64-bit, six-beat header layout to a parametrised datapath width.
- Adds a per-frame sequence counter, a timestamp counter and IPv4 checksum generation.
- Sits between the PCIe-RX TLP FIFO and the 10G/25G Ethernet MAC TX AXI-Stream.

Parameters:
DATA_WIDTH, 64, stream width in bits; legal values 64 or 128 (48-byte header = 6 or 3 beats).
SEQ_WIDTH, 10, sequence-number width; the field is zero-extended into the 16-bit NetTLP seq field.
UDP_PORT_CPL, 16'h3000, UDP port used when tlp_is_cpl=1.
UDP_PORT_MR, 16'h4000, UDP port used when tlp_is_cpl=0.
IP_TTL, 8'd64, IPv4 TTL.

Ports:
eth_clk  in  1  stream clock
eth_rst  in  1  synchronous, active-high reset
cfg_src_mac  in  48  source MAC
cfg_dst_mac  in  48  destination MAC
cfg_src_ip  in  32  source IPv4
cfg_dst_ip  in  32  destination IPv4
s_tvalid  in  1  TLP beat valid
s_tready  out  1  TLP beat accept
s_tdata  in  DATA_WIDTH  TLP bytes, byte k at [8k+7:8k]
s_tkeep  in  DATA_WIDTH/8  byte enables, contiguous from LSB, partial only on tlast
s_tlast  in  1  last TLP beat
s_tlp_len  in  12  TLP byte length (1..4095), valid with first beat
s_tlp_is_cpl  in  1  selects UDP source/dest port, valid with first beat
m_tvalid  out  1  frame beat valid
m_tready  in  1  MAC accept
m_tdata  out  DATA_WIDTH  frame bytes, byte k at [8k+7:8k]
m_tkeep  out  DATA_WIDTH/8  byte enables
m_tlast  out  1  last frame beat
seq_num  out  SEQ_WIDTH  sequence number of the next frame

Behaviour:
- Reset values: all outputs are 0, state is IDLE, seq counter is 0, timestamp counter is 0.
- State machine IDLE -> HDR -> PAYLOAD -> IDLE:
  - IDLE: s_tready=0. On s_tvalid=1, capture s_tlp_len, s_tlp_is_cpl, seq and timestamp, then go to HDR. The first TLP beat is not consumed.
  - HDR: emit 48/(DATA_WIDTH/8) header beats, all with tkeep all-ones and tlast=0. A beat counter advances only on m_tvalid&m_tready. After the final header beat is accepted, go to PAYLOAD.
  - PAYLOAD: pass-through, m_tvalid=s_tvalid, s_tready=m_tready, data/keep/last forwarded combinationally. A handshake on s_tlast returns to IDLE. No bubble is required between frames beyond one IDLE cycle.
- Header fields, network byte order:
  - Ethernet: dst MAC, src MAC, EtherType 0x0800.
  - IPv4: ver/IHL 0x45, TOS 0, tot_len = 34 + len, id 0, flags/frag 0x4000 (DF), TTL IP_TTL, proto 17, checksum, src IP, dst IP.
  - UDP: sport = dport = selected port, UDP length = 14 + len, checksum 0.
  - NetTLP: seq = {6'b0, seq[SEQ_WIDTH-1:0]} zero-extended to 16 bits, then 32-bit timestamp.
- IPv4 checksum: one's-complement sum of the ten 16-bit header words with end-around carry folding, then inverted. It must be registered before the first header beat carrying it is presented. HDR may insert at most 2 pipeline cycles before the first header beat.
- seq increments by 1 when the frame's tlast handshakes. It wraps (2^SEQ_WIDTH - 1) -> 0.
- Timestamp counter is free-running: +1 every eth_clk, wraps 0xFFFFFFFF -> 0.
- m_tdata/m_tvalid must hold stable while m_tvalid=1 and m_tready=0.
- Config inputs are sampled at the IDLE->HDR transition only. Changes mid-frame do not affect the current frame.
- eth_rst asserted mid-frame: next cycle returns to IDLE with outputs 0. The partial frame is abandoned; the MAC is responsible for discarding runts. seq and timestamp reset to 0.
- s_tlast with s_tlp_len mismatch: not checked; lengths come from s_tlp_len.

Optional Feature:
NETTLP_TSTAMP_EN:
- Defined: the NetTLP timestamp field carries the captured counter value.
- Undefined: the timestamp field is 32'h0, the counter is not instantiated, and the checksum is unaffected (it covers the IP header only).

Test Plan:
1. DATA_WIDTH=64, single 16-byte TLP, len=16, cpl=1, m_tready=1 -> 8 beats: 6 header + 2 payload. tot_len=0x0032, UDP len=0x001E, ports 0x3000, tlast on beat 8 with tkeep=0xFF.
2. DATA_WIDTH=128, 12-byte MWr TLP, len=12, cpl=0 -> 3 header beats + 1 payload beat with tkeep=0x0FFF. Ports 0x4000. IP checksum matches a software reference.
3. 1025 back-to-back frames -> seq fields 0..1023 then 0. seq_num reads 1 after the 1025th frame.
4. m_tready toggled 1-0-1 per cycle during header and payload -> output identical to the ready=1 case, with no dropped or duplicated beats.
5. eth_rst pulsed during the 3rd header beat -> next cycle m_tvalid=0, s_tready=0, seq_num=0. The following frame has seq=0 and a correct header.
6. NETTLP_TSTAMP_EN undefined -> timestamp bytes 0x00000000. With the macro defined, two frames started 100 cycles apart differ in timestamp by 100.
